// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: captures a pattern, a length and a repeat count, then
// shifts pattern[len-1:0] out MSB-first as a registered serial stream. Each
// repetition after the first is preceded by a single idle gap cycle. A one-cycle
// done pulse follows the last bit.
// The repeat count port is named rpt because "repeat" is a reserved word.
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int RPT_W = 4,
    parameter int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [RPT_W-1:0] rpt,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;
    logic [RPT_W-1:0] rem_q;
    // tail_q: the final bit of the current repetition is on x this cycle
    logic             tail_q;

    logic [LEN_W-1:0] len_c;
    logic             cur_bit;

    // Clamp the requested length to the pattern width and select the bit at idx
    always_comb begin
        len_c   = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
        cur_bit = |(pat_q & (WIDTH'(1) << idx_q));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len_c == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (tail_q) begin
                    state_nxt = (rem_q != '0) ? GAP : DONE;
                end
            end
            GAP:     state_nxt = SHIFT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Capture registers, bit/repeat counters and the registered serial output.
    // x lags the state by one edge: the first SHIFT cycle is a lead cycle, and
    // SHIFT is held one extra cycle (tail_q) so that GAP/DONE line up with the
    // cycle after the last visible bit. GAP both drives its idle cycle and
    // loads the first bit of the next repetition so no extra lead is inserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            tail_q  <= 1'b0;
            x       <= 1'b0;
            x_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    tail_q  <= 1'b0;
                    if (start) begin
                        pat_q <= pattern;
                        len_q <= len_c;
                        rem_q <= rpt;
                        idx_q <= (len_c == '0) ? '0 : len_c - LEN_W'(1);
                    end
                end
                SHIFT: begin
                    if (!tail_q) begin
                        x       <= cur_bit;
                        x_valid <= 1'b1;
                        if (idx_q == '0) begin
                            tail_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q - LEN_W'(1);
                        end
                    end else begin
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                        tail_q  <= 1'b0;
                        idx_q   <= len_q - LEN_W'(1);
                    end
                end
                GAP: begin
                    x       <= cur_bit;
                    x_valid <= 1'b1;
                    if (rem_q != '0) begin
                        rem_q <= rem_q - RPT_W'(1);
                    end
                    if (idx_q == '0) begin
                        tail_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q - LEN_W'(1);
                    end
                end
                DONE: begin
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    tail_q  <= 1'b0;
                end
                default: begin
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench for serial_pattern_gen. The driver applies inputs once per
// cycle; whenever its model says a start is accepted, the full per-cycle busy
// trace ({x_valid, x, done}) and the done cycle are queued. The monitor pops
// and compares on every busy cycle, and checks quiet outputs when idle.
module tb_serial_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] rpt;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int free_at = 0;

    logic [2:0] exp_q[$];
    int         done_q[$];

    serial_pattern_gen #(.WIDTH(8), .RPT_W(4), .LEN_W(4)) dut (
        .clk     (clk),
        .reset   (rst),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .rpt     (rpt),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clamp_len(input int l);
        return (l > 8) ? 8 : l;
    endfunction

    // Cycles the block stays busy: lead cycle, all bits, gap cycles, done cycle
    function automatic int busy_len(input int l, input int r);
        int lc;
        lc = clamp_len(l);
        if (lc == 0) return 1;
        return (r + 1) * lc + r + 2;
    endfunction

    task automatic expect_txn(input int cap, input logic [7:0] p, input int l, input int r);
        int lc;
        lc = clamp_len(l);
        if (lc == 0) begin
            exp_q.push_back(3'b001);
        end else begin
            exp_q.push_back(3'b000);
            for (int t = 0; t <= r; t++) begin
                if (t > 0) exp_q.push_back(3'b000);
                for (int b = lc - 1; b >= 0; b--) exp_q.push_back({1'b1, p[b], 1'b0});
            end
            exp_q.push_back(3'b001);
        end
        done_q.push_back(cap + busy_len(l, r) - 1);
    endtask

    // Apply inputs for one cycle; a start seen by an idle block is a capture
    task automatic step(input logic s, input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        start   = s;
        pattern = p;
        len     = l;
        rpt     = r;
        @(posedge clk);
        #1;
        if (s && cyc >= free_at) begin
            expect_txn(cyc, p, int'(l), int'(r));
            free_at = cyc + busy_len(int'(l), int'(r)) + 1;
        end
    endtask

    task automatic drain();
        while (cyc < free_at) step(1'b0, 8'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic run_txn(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        step(1'b1, p, l, r);
        drain();
    endtask

    // Monitor: compare every busy cycle against the queued trace
    logic [2:0] mon_e;
    int         mon_dc;
    always @(negedge clk) begin
        if (busy) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL busy_unexpected cyc=%0d got busy=1 want busy=0", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({x_valid, x, done} !== mon_e) begin
                    bad++;
                    $display("FAIL trace cyc=%0d got {xv,x,done}=%b want %b", cyc, {x_valid, x, done}, mon_e);
                end
            end
            if (done) begin
                total++;
                if (done_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected cyc=%0d got done=1 want none", cyc);
                end else begin
                    mon_dc = done_q.pop_front();
                    if (cyc != mon_dc) begin
                        bad++;
                        $display("FAIL done_cycle got cyc=%0d want cyc=%0d", cyc, mon_dc);
                    end
                end
            end
        end else begin
            total++;
            if ({x_valid, x, done} !== 3'b000) begin
                bad++;
                $display("FAIL idle_outputs cyc=%0d got {xv,x,done}=%b want 000", cyc, {x_valid, x, done});
            end
        end
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        rpt     = '0;
        #2;
        total++;
        if ({x, x_valid, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_state got {x,xv,busy,done}=%b want 0000", {x, x_valid, busy, done});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        free_at = 0;

        run_txn(8'h0E, 4'd5, 4'd0);
        run_txn(8'h02, 4'd2, 4'd2);
        for (int i = 0; i < 12; i++) step(1'b1, 8'h09, 4'd4, 4'd0);
        drain();
        run_txn(8'h5C, 4'd0, 4'd3);
        run_txn(8'hA5, 4'd12, 4'd0);
        run_txn(8'h01, 4'd1, 4'd15);
        run_txn(8'hC3, 4'd3, 4'd15);

        // Abort during the third bit of a 5-bit transmission
        step(1'b1, 8'h16, 4'd5, 4'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'($urandom), 4'($urandom), 4'($urandom));
        #1;
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        #1;
        total++;
        if ({x, x_valid, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL abort_reset got {x,xv,busy,done}=%b want 0000", {x, x_valid, busy, done});
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        free_at = 0;
        run_txn(8'h16, 4'd5, 4'd0);

        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 3) == 0),
                 8'($urandom),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3)));
        end
        drain();
        step(1'b0, 8'h00, 4'd0, 4'd0);
        step(1'b0, 8'h00, 4'd0, 4'd0);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL trace_left got %0d entries want 0", exp_q.size());
        end
        total++;
        if (done_q.size() != 0) begin
            bad++;
            $display("FAIL done_left got %0d pulses missing want 0", done_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_pattern_gen.md
SERIAL_PATTERN_GEN -- requirements
Module: serial_pattern_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: maximum pattern length in bits.
REQ-002 The block SHALL have parameter RPT_W, default 4: width of the repeat-count input.
REQ-003 The block SHALL have parameter LEN_W, default $clog2(WIDTH)+1: width of the length input.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-007 pattern  input  WIDTH  bits to transmit; bits [len-1:0] are used.
REQ-008 len  input  LEN_W  number of bits per transmission.
REQ-009 repeat  input  RPT_W  number of additional transmissions after the first.
REQ-010 x  output  1  serial data bit, registered, 0 whenever x_valid=0.
REQ-011 x_valid  output  1  x carries a pattern bit this cycle.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, GAP and DONE.
REQ-015 In IDLE with start=1 at an edge, the block SHALL capture pattern, len and repeat into internal registers and enter SHIFT, or enter DONE if the captured len=0.
REQ-016 len>WIDTH SHALL be clamped to WIDTH at capture.
REQ-017 Latency: when start is sampled at edge k, the first bit SHALL be valid in the cycle after edge k+1, so x_valid=1 follows edge k+1.
REQ-018 SHIFT SHALL emit one bit per cycle, MSB-first from captured pattern[len-1] down to pattern[0], with x_valid=1.
REQ-019 After the last bit, the FSM SHALL enter GAP if the remaining repeat count is nonzero, otherwise DONE.
REQ-020 GAP SHALL last exactly one cycle with x=0 and x_valid=0, decrement the remaining repeat count, and return to SHIFT at bit len-1.
REQ-021 DONE SHALL last exactly one cycle with done=1 and x_valid=0, then go to IDLE.
REQ-022 The transmission duration from the first x_valid to done SHALL be (repeat+1)*len + repeat + 1 cycles.
REQ-023 start SHALL be ignored in SHIFT, GAP and DONE; start held high through DONE SHALL be accepted on the first IDLE edge.
REQ-024 busy SHALL be 1 in SHIFT, GAP and DONE, and 0 in IDLE.
REQ-025 Changes to pattern, len and repeat after capture SHALL NOT affect the transmission in progress.
REQ-026 The bit index and repeat counters SHALL NOT wrap: the index stops at 0, and repeat=all-ones SHALL yield exactly 2^RPT_W transmissions.

Reset
REQ-027 Asserting reset SHALL immediately force state=IDLE, x=0, x_valid=0, busy=0, done=0, and clear all captured registers and counters.
REQ-028 Reset during SHIFT or GAP SHALL abort the transmission without a done pulse.
REQ-029 After reset deasserts, the first accepted start SHALL behave exactly as in REQ-015 through REQ-021.

Verification
REQ-030 pattern=5'b01110, len=5, repeat=0, start pulse -> x=0,1,1,1,0 with x_valid=1 on 5 consecutive cycles, then done=1 for 1 cycle, then busy=0.
REQ-031 pattern=2'b10, len=2, repeat=2 -> x_valid=1,1,0,1,1,0,1,1 with x=1,0,-,1,0,-,1,0, then done=1 for 1 cycle.
REQ-032 start held high for 12 cycles, len=4, repeat=0 -> first transmission of 4 bits, done, one IDLE cycle, then a second transmission begins.
REQ-033 len=0, start pulse -> no x_valid; done=1 in the cycle after capture; busy high for exactly 1 cycle.
REQ-034 WIDTH=8, len=12, pattern=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1, then done.
REQ-035 reset asserted during the 3rd bit of a len=5 transmission -> all outputs 0 immediately and no done pulse; a subsequent start transmits correctly.
